// File: rtl/dm_access_unit.sv
// ---------------------------------------------------------------------------
// dm_access_unit
//
// MEM-stage data-memory access unit. It turns a load/store from EX/MEM into a
// word-aligned bus transaction with byte enables. Load data comes back
// sign- or zero-extended. The unit tells the pipeline when it must stall
// (dmRequireStall) and flags address or bus errors (dmExcept) to CP0.
// A misaligned access traps and never reaches the bus.
//
// Optional feature: define DM_BUS_TIMEOUT_EN to enable the bus wait timeout.
// When it is enabled, a transaction that gets no ack within TIMEOUT_CYCLES
// BUSY cycles is abandoned and reported as a bus error. Without the macro the
// unit waits for bus_ack for as long as it takes.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   memRead/Write   load / store presented in MEM (mutually exclusive)
//   memSize         00 byte, 01 half, 10/11 word
//   memSigned       1 = sign-extend loaded data
//   addr, wdata     byte address and right-justified store data
//   kill            squash the access currently presented
//   pipeStall       EX/MEM held by another stall source
//   rdata           extended load result, valid in DONE
//   dmRequireStall  hold pipeline while an access is in flight
//   dmExcept        misalignment (or bus timeout) for the current access
//   bus_*           registered request side of the data bus
//   bus_rdata/ack   read data and one-cycle completion strobe
//
// State table
//   state   | meaning
//   IDLE    | no access in flight; launch or trap a presented access
//   BUSY    | bus_req held; waiting for bus_ack (or timeout)
//   DONE    | result available; pipeline advances when pipeStall drops
// ---------------------------------------------------------------------------
module dm_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memSize,
    input  logic        memSigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        kill,
    input  logic        pipeStall,
    output logic [31:0] rdata,
    output logic        dmRequireStall,
    output logic        dmExcept,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dm_access_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        is_byte, is_half;
    logic        access, misaligned, launch, kill_any;
    logic        timeout, bus_err;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;

    // The load shape is captured at launch. The result is then formed from
    // these copies rather than from the live pipeline inputs.
    logic [1:0]  ld_size;
    logic [1:0]  ld_off;
    logic        ld_signed;
    logic        kill_flag;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign is_byte    = (memSize == 2'b00);
    assign is_half    = (memSize == 2'b01);
    assign access     = (memRead | memWrite) & ~kill;
    assign misaligned = (is_half & addr[0]) |
                        (~is_byte & ~is_half & (addr[1:0] != 2'b00));
    assign launch     = (state == ST_IDLE) & access & ~misaligned;
    // A kill in the ack cycle itself squashes the result just like a latched one.
    assign kill_any   = kill_flag | kill;

    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = wdata;
        if (is_byte) begin
            be_lane    = 4'b0001 << addr[1:0];
            wdata_lane = {4{wdata[7:0]}};
        end else if (is_half) begin
            be_lane    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        ld_byte  = 8'h00;
        load_ext = bus_rdata;
        case (ld_off)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ld_size)
            2'b00:   load_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: load_ext = bus_rdata;
        endcase
    end

`ifdef DM_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;

    // The counter holds the number of BUSY cycles already spent without an
    // ack. So the cycle where it reads TIMEOUT_CYCLES-1 is the last one allowed.
    assign timeout = (state == ST_BUSY) & ~bus_ack & (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
            bus_err <= 1'b0;
        end else begin
            if (launch)
                tmo_cnt <= 8'd0;
            else if (state == ST_BUSY && !bus_ack)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (state == ST_BUSY)
                bus_err <= timeout & ~kill_any;
            else if (state_nxt != ST_DONE)
                bus_err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        dmRequireStall = 1'b0;
        dmExcept       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        dmExcept = 1'b1;
                    end else begin
                        dmRequireStall = 1'b1;
                        state_nxt      = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                dmRequireStall = 1'b1;
                if (bus_ack || timeout)
                    state_nxt = kill_any ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                dmExcept = bus_err;
                if (kill || !pipeStall)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            rdata     <= 32'd0;
            ld_size   <= 2'd0;
            ld_off    <= 2'd0;
            ld_signed <= 1'b0;
            kill_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        bus_req   <= 1'b1;
                        bus_we    <= memWrite;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_lane;
                        bus_wdata <= wdata_lane;
                        ld_size   <= memSize;
                        ld_off    <= addr[1:0];
                        ld_signed <= memSigned;
                        kill_flag <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (kill)
                        kill_flag <= 1'b1;
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        kill_flag <= 1'b0;
                        if (!bus_we && !kill_any)
                            rdata <= load_ext;
                    end else if (timeout) begin
                        bus_req   <= 1'b0;
                        kill_flag <= 1'b0;
                        if (!kill_any)
                            rdata <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, memSigned, kill, pipeStall;
    logic [1:0]  memSize;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        dmRequireStall, dmExcept;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int          checks = 0;
    int          errors = 0;
    int          req_rises = 0;
    logic        req_q = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    dm_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
        .memSigned(memSigned), .addr(addr), .wdata(wdata),
        .kill(kill), .pipeStall(pipeStall),
        .rdata(rdata), .dmRequireStall(dmRequireStall), .dmExcept(dmExcept),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always @(negedge clk) begin
        if (bus_req && !req_q) req_rises++;
        req_q <= bus_req;
    end

    // Reference model: lane and extension rules written as plain arithmetic.
    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == 2'b00) return 4'(1 << off);
        if (sz == 2'b01) return 4'(3 << (off & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                               input logic [31:0] a, input logic [31:0] brd);
        logic [31:0] v;
        int off = int'(a % 4);
        if (sz == 2'b00) begin
            v = (brd >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = (brd >> (8 * (off & 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = brd;
        end
        return v;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b01) return (a % 2) != 0;
        if (sz[1]) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        memRead = 0; memWrite = 0; memSize = 0; memSigned = 0;
        addr = 0; wdata = 0; kill = 0; pipeStall = 0; bus_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one access at +1 after an edge and acks it in BUSY cycle
    // ack_cyc (ack_cyc <= 0: never ack). It returns what it observed.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                              input int ack_cyc, input logic [31:0] brd,
                              output int stalls, output logic exc0, output logic req1,
                              output logic [31:0] o_addr, output logic [31:0] o_wdata,
                              output logic [3:0] o_be, output logic o_we,
                              output logic [31:0] o_rdata, output logic exc_done,
                              output logic req_done);
        int busy_cyc;
        memRead = rd; memWrite = wr; memSize = sz; memSigned = sgn;
        addr = a; wdata = wd;
        #1;
        exc0 = dmExcept; stalls = 0; busy_cyc = 0;
        o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0; exc_done = 0; req_done = 0;
        if (!dmRequireStall) begin
            step();
            req1 = bus_req; o_rdata = rdata;
            idle_inputs();
            return;
        end
        stalls = 1;
        step();
        req1 = bus_req; o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
        while (dmRequireStall && busy_cyc < 300) begin
            stalls++; busy_cyc++;
            if (busy_cyc == ack_cyc) begin bus_ack = 1; bus_rdata = brd; end
            step();
            bus_ack = 0; bus_rdata = $urandom;
        end
        if (busy_cyc >= 300) begin
            checks++; errors++;
            $display("FAIL busy_bound: still stalled after %0d cycles, required completion", busy_cyc);
        end
        o_rdata = rdata; exc_done = dmExcept; req_done = bus_req;
        idle_inputs();
        step();
    endtask

    task automatic test_reset();
        idle_inputs(); bus_rdata = 0;
        rst = 1; step(); step(); rst = 0;
        checks++; if ({bus_req, bus_we, bus_be} !== 6'd0) begin errors++;
            $display("FAIL reset_bus_ctl: got %b want 0", {bus_req, bus_we, bus_be}); end
        checks++; if ({bus_addr, bus_wdata, rdata} !== 96'd0) begin errors++;
            $display("FAIL reset_data: got addr %h wdata %h rdata %h want 0", bus_addr, bus_wdata, rdata); end
        checks++; if ({dmRequireStall, dmExcept} !== 2'b00) begin errors++;
            $display("FAIL reset_flags: got %b want 00", {dmRequireStall, dmExcept}); end
        // Reset with a request in flight must drop bus_req.
        memRead = 1; memSize = 2'b10; addr = 32'h80;
        step();
        checks++; if (bus_req !== 1'b1) begin errors++;
            $display("FAIL mid_launch: bus_req got %b want 1", bus_req); end
        idle_inputs(); rst = 1; step(); rst = 0;
        checks++; if ({bus_req, dmRequireStall} !== 2'b00) begin errors++;
            $display("FAIL mid_reset: req/stall got %b want 00", {bus_req, dmRequireStall}); end
        exp_rdata = 0;
        step();
    endtask

    task automatic test_directed();
        int st; logic e0, r1, we, ed, rq; logic [31:0] oa, ow, orr; logic [3:0] be;
        run_access(1, 0, 2'b10, 0, 32'h100, 0, 3, 32'hDEADBEEF, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (st !== 4) begin errors++; $display("FAIL lw_stalls: got %0d want 4", st); end
        checks++; if (be !== 4'b1111 || oa !== 32'h100) begin errors++;
            $display("FAIL lw_bus: be %b addr %h want 1111 00000100", be, oa); end
        checks++; if (orr !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h want deadbeef", orr); end
        run_access(1, 0, 2'b00, 1, 32'h103, 0, 1, 32'h80FF0000, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (be !== 4'b1000 || st !== 2) begin errors++;
            $display("FAIL lb_bus: be %b stalls %0d want 1000 2", be, st); end
        checks++; if (orr !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", orr); end
        run_access(1, 0, 2'b00, 0, 32'h103, 0, 1, 32'h80FF0000, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (orr !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", orr); end
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 2, 0, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (be !== 4'b1100 || ow !== 32'hABCDABCD || we !== 1'b1) begin errors++;
            $display("FAIL sh_bus: be %b wdata %h we %b want 1100 abcdabcd 1", be, ow, we); end
        checks++; if (orr !== 32'h00000080) begin errors++; $display("FAIL sh_rdata_kept: got %h want 00000080", orr); end
        run_access(1, 0, 2'b10, 0, 32'h101, 0, 1, 0, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (e0 !== 1'b1 || st !== 0 || r1 !== 1'b0) begin errors++;
            $display("FAIL lw_misaligned: exc %b stalls %0d req %b want 1 0 0", e0, st, r1); end
        exp_rdata = 32'h00000080;
    endtask

    task automatic test_random();
        int st, ackc, rises0; logic e0, r1, we, ed, rq, rd, sgn, mis;
        logic [31:0] oa, ow, orr, a, wd, brd; logic [3:0] be; logic [1:0] sz;
        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
            a = $urandom; wd = $urandom; brd = $urandom; ackc = $urandom_range(1, 4);
            if ($urandom_range(0, 3) != 0) a = a - (a % (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4)));
            mis = model_misaligned(sz, a);
            rises0 = req_rises;
            run_access(rd, !rd, sz, sgn, a, wd, ackc, brd, st, e0, r1, oa, ow, be, we, orr, ed, rq);
            if (mis) begin
                checks++; if (e0 !== 1'b1 || st !== 0 || r1 !== 1'b0 || req_rises != rises0) begin errors++;
                    $display("FAIL rnd_mis[%0d]: exc %b stalls %0d req %b want 1 0 0", n, e0, st, r1); end
            end else begin
                if (rd) exp_rdata = model_load(sz, sgn, a, brd);
                checks++; if (e0 !== 1'b0 || ed !== 1'b0 || st !== ackc + 1) begin errors++;
                    $display("FAIL rnd_stall[%0d]: exc %b stalls %0d want 0 %0d", n, e0, st, ackc + 1); end
                checks++; if (oa !== (a & ~32'd3) || be !== model_be(sz, a) || we !== !rd) begin errors++;
                    $display("FAIL rnd_bus[%0d]: addr %h be %b we %b want %h %b %b", n, oa, be, we,
                             a & ~32'd3, model_be(sz, a), !rd); end
                if (!rd) begin
                    checks++; if (ow !== model_wdata(sz, wd)) begin errors++;
                        $display("FAIL rnd_wdata[%0d]: got %h want %h", n, ow, model_wdata(sz, wd)); end
                end
                checks++; if (orr !== exp_rdata) begin errors++;
                    $display("FAIL rnd_rdata[%0d]: got %h want %h", n, orr, exp_rdata); end
            end
        end
    endtask

    task automatic test_kill();
        memRead = 1; memSize = 2'b10; addr = 32'h300;
        step();
        kill = 1; step(); kill = 0;
        checks++; if ({dmRequireStall, bus_req} !== 2'b11) begin errors++;
            $display("FAIL kill_busy_held: stall/req %b want 11", {dmRequireStall, bus_req}); end
        step();
        bus_ack = 1; bus_rdata = 32'h55AA55AA; step(); bus_ack = 0;
        // Back in IDLE with no DONE cycle, so the still-presented load relaunches.
        checks++; if (dmRequireStall !== 1'b1 || bus_req !== 1'b0) begin errors++;
            $display("FAIL kill_to_idle: stall %b req %b want 1 0", dmRequireStall, bus_req); end
        checks++; if (rdata !== exp_rdata) begin errors++;
            $display("FAIL kill_rdata: got %h want %h", rdata, exp_rdata); end
        kill = 1; #1;
        checks++; if (dmRequireStall !== 1'b0) begin errors++;
            $display("FAIL kill_idle_block: stall %b want 0", dmRequireStall); end
        step();
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL kill_no_launch: req %b want 0", bus_req); end
        idle_inputs(); step();
    endtask

    task automatic test_pipestall_done();
        int rises0 = req_rises, bad = 0;
        memRead = 1; memSize = 2'b10; addr = 32'h400;
        step();
        bus_ack = 1; bus_rdata = 32'h0BADF00D; step(); bus_ack = 0;
        pipeStall = 1;
        for (int i = 0; i < 3; i++) begin
            if (dmRequireStall !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'h0BADF00D) bad++;
            step();
        end
        pipeStall = 0; step(); idle_inputs(); step();
        exp_rdata = 32'h0BADF00D;
        checks++; if (bad != 0) begin errors++; $display("FAIL done_hold: %0d bad DONE cycles want 0", bad); end
        checks++; if (req_rises - rises0 != 1) begin errors++;
            $display("FAIL done_single_req: got %0d requests want 1", req_rises - rises0); end
    endtask

`ifdef DM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int st; logic e0, r1, we, ed, rq; logic [31:0] oa, ow, orr; logic [3:0] be;
        run_access(1, 0, 2'b10, 0, 32'h700, 0, 1, 32'hCAFEF00D, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (orr !== 32'hCAFEF00D) begin errors++; $display("FAIL tmo_pre_rdata: got %h want cafef00d", orr); end
        run_access(1, 0, 2'b10, 0, 32'h704, 0, 0, 0, st, e0, r1, oa, ow, be, we, orr, ed, rq);
        checks++; if (st !== TMO + 1 || rq !== 1'b0) begin errors++;
            $display("FAIL tmo_stalls: stalls %0d req %b want %0d 0", st, rq, TMO + 1); end
        checks++; if (ed !== 1'b1 || orr !== 32'd0) begin errors++;
            $display("FAIL tmo_done: exc %b rdata %h want 1 0", ed, orr); end
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF; step(); bus_ack = 0;
        checks++; if (rdata !== 32'd0 || bus_req !== 1'b0 || dmExcept !== 1'b0) begin errors++;
            $display("FAIL tmo_late_ack: rdata %h req %b exc %b want 0 0 0", rdata, bus_req, dmExcept); end
        exp_rdata = 0;
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        memRead = 1; memSize = 2'b10; addr = 32'h600;
        step();
        for (int i = 0; i < 30; i++) begin
            if (!(bus_req && dmRequireStall) || dmExcept) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wait_forever: %0d bad cycles want 0", bad); end
        bus_ack = 1; bus_rdata = 32'h13579BDF; step(); bus_ack = 0;
        checks++; if (dmRequireStall !== 1'b0 || rdata !== 32'h13579BDF) begin errors++;
            $display("FAIL wait_done: stall %b rdata %h want 0 13579bdf", dmRequireStall, rdata); end
        idle_inputs(); step();
        exp_rdata = 32'h13579BDF;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle_inputs(); bus_rdata = 0;
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_pipestall_done();
`ifdef DM_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
